phase_sequencer: RTL and testbench

- Parametrised run-controller for multi-phase cipher datapaths (init → KSA → PRGA → …).
- Launches NUM_PHASES sub-blocks in order over the team's rdy/en handshake. A phase mask can skip phases.
- Grants the single shared S-memory port to whichever phase is active.
- Adds a per-phase watchdog, abort and restart. The fixed two-phase controller and hand-written mux had none of these.

---
 rtl/phase_sequencer_if.sv | 33 +++
 rtl/phase_sequencer.sv | 144 ++++++++++++++
 tb/tb_phase_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/phase_sequencer_if.sv
// Bundle for phase_sequencer: run control, per-phase rdy/en handshake with address and write
// data, the shared S-memory port, and status. The master drives the inputs; the sequencer is the slave.
interface phase_sequencer_if #(
  parameter int unsigned NUM_PHASES = 3,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 8
);
  logic                         start;
  logic                         abort;
  logic [NUM_PHASES-1:0]        phase_mask;
  logic [NUM_PHASES-1:0]        rdy_in;
  logic [NUM_PHASES-1:0]        en_out;
  logic [NUM_PHASES*ADDR_W-1:0] addr_in;
  logic [NUM_PHASES*DATA_W-1:0] wrdata_in;
  logic [NUM_PHASES-1:0]        wren_in;
  logic [ADDR_W-1:0]            mem_addr;
  logic [DATA_W-1:0]            mem_wrdata;
  logic                         mem_wren;
  logic [2:0]                   cur_phase;
  logic                         rdy;
  logic                         done;
  logic                         err;

  modport master (
    output start, abort, phase_mask, rdy_in, addr_in, wrdata_in, wren_in,
    input  en_out, mem_addr, mem_wrdata, mem_wren, cur_phase, rdy, done, err
  );

  modport slave (
    input  start, abort, phase_mask, rdy_in, addr_in, wrdata_in, wren_in,
    output en_out, mem_addr, mem_wrdata, mem_wren, cur_phase, rdy, done, err
  );
endinterface

// File: rtl/phase_sequencer.sv
// Run controller that launches masked sub-blocks in ascending order over rdy/en, grants the shared
// S-memory port to the active phase, and guards each phase with a watchdog and abort.
module phase_sequencer #(
  parameter int unsigned NUM_PHASES = 3,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned TIMEOUT_W  = 16
) (
  input logic              clk,
  input logic              rst,
  phase_sequencer_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StArm, StFire, StRun, StDone, StError} state_e;

  localparam logic [TIMEOUT_W-1:0] WdogMax = '1;

  state_e                state_q, state_d;
  logic [2:0]            cur_q, cur_d;
  logic [NUM_PHASES-1:0] mask_q, mask_d;
  logic [TIMEOUT_W-1:0]  wdog_q, wdog_d;

  logic                  rdy_cur;
  logic                  wren_cur;
  logic [ADDR_W-1:0]     addr_cur;
  logic [DATA_W-1:0]     wrdata_cur;
  logic [NUM_PHASES-1:0] cur_onehot;
  logic [2:0]            first_idx, next_idx;
  logic                  first_any, next_any;
  logic                  active;

  // Descending scans so the lowest qualifying index is the one left standing.
  always_comb begin
    rdy_cur    = 1'b0;
    wren_cur   = 1'b0;
    addr_cur   = '0;
    wrdata_cur = '0;
    cur_onehot = '0;
    first_idx  = '0;
    first_any  = 1'b0;
    next_idx   = '0;
    next_any   = 1'b0;
    for (int i = NUM_PHASES - 1; i >= 0; i--) begin
      if (cur_q == 3'(i)) begin
        rdy_cur       = bus.rdy_in[i];
        wren_cur      = bus.wren_in[i];
        addr_cur      = bus.addr_in[i*ADDR_W +: ADDR_W];
        wrdata_cur    = bus.wrdata_in[i*DATA_W +: DATA_W];
        cur_onehot[i] = 1'b1;
      end
      if (bus.phase_mask[i]) begin
        first_idx = 3'(i);
        first_any = 1'b1;
      end
      if (mask_q[i] && (3'(i) > cur_q)) begin
        next_idx = 3'(i);
        next_any = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    mask_d  = mask_q;
    wdog_d  = wdog_q;
    unique case (state_q)
      StIdle, StDone, StError: begin
        if (bus.start) begin
          mask_d = bus.phase_mask;
          wdog_d = '0;
          if (first_any) begin
            cur_d   = first_idx;
            state_d = StArm;
          end else begin
            state_d = StDone;
          end
        end
      end
      StArm: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else if (rdy_cur) begin
          state_d = StFire;
        end else begin
          wdog_d = wdog_q + 1'b1;
          if (wdog_q == WdogMax - 1'b1) state_d = StError;
        end
      end
      StFire: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else begin
          wdog_d  = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else if (rdy_cur) begin
          if (next_any) begin
            cur_d   = next_idx;
            wdog_d  = '0;
            state_d = StArm;
          end else begin
            state_d = StDone;
          end
        end else begin
          wdog_d = wdog_q + 1'b1;
          if (wdog_q == WdogMax - 1'b1) state_d = StError;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cur_q   <= '0;
      mask_q  <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      mask_q  <= mask_d;
      wdog_q  <= wdog_d;
    end
  end

  assign active = (state_q == StArm) || (state_q == StFire) || (state_q == StRun);

  // An aborting FIRE cycle must not launch a sub-block nobody will wait for.
  assign bus.en_out     = ((state_q == StFire) && !bus.abort) ? cur_onehot : '0;
  assign bus.mem_addr   = active ? addr_cur : '0;
  assign bus.mem_wrdata = active ? wrdata_cur : '0;
  assign bus.mem_wren   = active && wren_cur;
  assign bus.cur_phase  = cur_q;
  assign bus.rdy        = !active;
  assign bus.done       = (state_q == StDone);
  assign bus.err        = (state_q == StError);

endmodule

// File: tb/tb_phase_sequencer.sv
// Randomised bench for phase_sequencer: expected per-cycle ownership, enable pulses and end state
// are laid out from phase delays with plain arithmetic, then compared every cycle.
module tb_phase_sequencer;
  localparam int unsigned NP     = 3;
  localparam int unsigned AW     = 8;
  localparam int unsigned DW     = 8;
  localparam int unsigned TW     = 4;
  localparam int          TO_CYC = (1 << TW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic model_clr;

  int unsigned dly [NP];
  int          cnt [NP];

  logic [AW-1:0] a_v [NP];
  logic [DW-1:0] d_v [NP];
  logic [NP-1:0] w_v;

  int n_checks = 0;
  int n_errors = 0;

  phase_sequencer_if #(.NUM_PHASES(NP), .ADDR_W(AW), .DATA_W(DW)) bus ();

  phase_sequencer #(
    .NUM_PHASES(NP),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .TIMEOUT_W (TW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Sub-block models: rdy drops on the edge that samples en, returns dly[i] edges later.
  always @(posedge clk) begin
    for (int i = 0; i < NP; i++) begin
      if (model_clr) begin
        bus.rdy_in[i] <= 1'b1;
        cnt[i]        <= 0;
      end else if (bus.en_out[i]) begin
        bus.rdy_in[i] <= 1'b0;
        cnt[i]        <= int'(dly[i]);
      end else if (cnt[i] > 0) begin
        cnt[i] <= cnt[i] - 1;
        if (cnt[i] == 1) bus.rdy_in[i] <= 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_rand();
    for (int i = 0; i < NP; i++) begin
      a_v[i] = AW'($urandom);
      d_v[i] = DW'($urandom);
      bus.addr_in[i*AW +: AW]   = a_v[i];
      bus.wrdata_in[i*DW +: DW] = d_v[i];
    end
    w_v = NP'($urandom);
    bus.wren_in = w_v;
  endtask

  task automatic check_cycle(input int owner, input logic [NP-1:0] en_exp, input logic exp_done,
                             input logic exp_err);
    check("en_out", 32'(bus.en_out), 32'(en_exp));
    check("done", 32'(bus.done), 32'(exp_done));
    check("err", 32'(bus.err), 32'(exp_err));
    check("rdy", 32'(bus.rdy), 32'(owner < 0));
    if (owner >= 0) begin
      check("cur_phase", 32'(bus.cur_phase), owner);
      check("mem_wren", 32'(bus.mem_wren), 32'(w_v[owner]));
      check("mem_addr", 32'(bus.mem_addr), 32'(a_v[owner]));
      check("mem_wrdata", 32'(bus.mem_wrdata), 32'(d_v[owner]));
    end else begin
      check("mem_wren_idle", 32'(bus.mem_wren), 0);
      check("mem_addr_idle", 32'(bus.mem_addr), 0);
      check("mem_wrdata_idle", 32'(bus.mem_wrdata), 0);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_clr = 1'b1;
    drive_rand();
    @(negedge clk);
    model_clr = 1'b0;
  endtask

  // One run: each set phase costs ARM + FIRE + (dly+1) RUN cycles; a hung phase times out after
  // TO_CYC RUN cycles. kill_c >= 0 injects abort+start (or rst) in that cycle.
  task automatic run_seq(input logic [NP-1:0] mask, input int hang_ph, input int kill_c,
                         input bit kill_rst, input bit abort_at_start);
    int            owner_s [128];
    logic [NP-1:0] en_s    [128];
    logic [NP-1:0] one;
    int            off;
    int            d;
    int            last;
    bit            ended_err;
    one = 1;
    for (int c = 0; c < 128; c++) begin
      owner_s[c] = -1;
      en_s[c]    = '0;
    end
    off       = 0;
    ended_err = 1'b0;
    for (int j = 0; j < NP; j++) begin
      if (mask[j] && !ended_err) begin
        d = (j == hang_ph) ? TO_CYC - 1 : int'(dly[j]);
        for (int k = 0; k < d + 3; k++) owner_s[off+k] = j;
        en_s[off+1] = one << j;
        off += d + 3;
        if (j == hang_ph) ended_err = 1'b1;
      end
    end
    last = off;

    @(negedge clk);
    bus.phase_mask = mask;
    bus.start      = 1'b1;
    bus.abort      = abort_at_start;
    drive_rand();
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      bus.start      = 1'b0;
      bus.abort      = 1'b0;
      bus.phase_mask = NP'($urandom);
      if (c == kill_c) begin
        if (kill_rst) begin
          rst       = 1'b1;
          model_clr = 1'b1;
        end else begin
          bus.abort = 1'b1;
          bus.start = 1'b1;
        end
      end
      drive_rand();
      #1;
      check_cycle(owner_s[c], en_s[c], (c == last) && !ended_err, (c == last) && ended_err);
      if (c == kill_c) begin
        @(negedge clk);
        rst       = 1'b0;
        model_clr = 1'b0;
        bus.abort = 1'b0;
        bus.start = 1'b0;
        drive_rand();
        #1;
        check_cycle(-1, '0, 1'b0, 1'b0);
        if (kill_rst) check("cur_phase_rst", 32'(bus.cur_phase), 0);
        break;
      end
    end
    if (kill_c < 0 && ended_err) check("cur_phase_err", 32'(bus.cur_phase), hang_ph);
  endtask

  task automatic rand_dly();
    for (int i = 0; i < NP; i++) dly[i] = $urandom_range(1, 12);
  endtask

  initial begin
    rst            = 1'b1;
    model_clr      = 1'b1;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.phase_mask = '0;
    for (int i = 0; i < NP; i++) dly[i] = 1;
    drive_rand();
    repeat (2) @(negedge clk);
    drive_rand();
    #1;
    check_cycle(-1, '0, 1'b0, 1'b0);
    check("cur_phase_reset", 32'(bus.cur_phase), 0);
    @(negedge clk);
    rst       = 1'b0;
    model_clr = 1'b0;

    // Full sequence with fixed delays.
    dly[0] = 5; dly[1] = 10; dly[2] = 3;
    run_seq(3'b111, -1, -1, 1'b0, 1'b0);
    settle();

    // Middle phase skipped.
    rand_dly();
    run_seq(3'b101, -1, -1, 1'b0, 1'b0);
    settle();

    // Empty mask goes straight to DONE.
    run_seq(3'b000, -1, -1, 1'b0, 1'b0);
    settle();

    // Phase 1 never returns rdy: watchdog trips, then a restart from phase 0.
    dly[0] = 4; dly[1] = 200; dly[2] = 2;
    run_seq(3'b111, 1, -1, 1'b0, 1'b0);
    settle();
    rand_dly();
    run_seq(3'b111, -1, -1, 1'b0, 1'b0);
    settle();

    // Abort (with start) in the third RUN cycle of phase 1.
    dly[0] = 3; dly[1] = 8; dly[2] = 2;
    run_seq(3'b111, -1, int'(dly[0]) + 3 + 4, 1'b0, 1'b0);
    settle();

    // Synchronous reset mid-RUN, then a clean full run.
    dly[0] = 2; dly[1] = 6; dly[2] = 4;
    run_seq(3'b111, -1, int'(dly[0]) + 3 + 3, 1'b1, 1'b0);
    settle();
    rand_dly();
    run_seq(3'b111, -1, -1, 1'b0, 1'b0);
    settle();

    // Random masks and delays; abort alongside start is ignored outside an active run.
    for (int n = 0; n < 25; n++) begin
      rand_dly();
      run_seq(NP'($urandom), -1, -1, 1'b0, 1'($urandom_range(0, 1)));
      settle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
